// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack port, and holds the IR for the control FSM.
// Define IFU_PERF_CNT_EN to add fetch/taken/stall performance counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        dec_ready,
  input  logic        stall,
  input  logic        beq,
  input  logic        bne,
  input  logic        j,
  input  logic        z,
  output logic [31:0] pc_out,
  output logic        fetch_err
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] taken_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RETRY, S_VALID} state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pc_out_q, pc_out_d;
  logic              instr_valid_q, instr_valid_d;
  logic              imem_req_q, imem_req_d;
  logic              fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [31:0] pc4, br_off, next_pc;
  logic        br_taken, accept;

  always_comb begin
    pc4      = pc_out_q + 32'd4;
    br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    // beq wins when the FSM illegally raises both branch controls
    br_taken = beq ? z : (bne & ~z);
    if (j)
      next_pc = {pc4[31:28], instr_q[25:0], 2'b00};
    else if (br_taken)
      next_pc = pc4 + br_off;
    else
      next_pc = pc4;
  end

  assign accept = (state_q == S_VALID) && dec_ready && !stall;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    instr_valid_d = instr_valid_q;
    fetch_err_d   = fetch_err_q;
    cnt_d         = cnt_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          pc_out_d      = pc_q;
          cnt_d         = '0;
          state_d       = S_VALID;
        end else if (TIMEOUT != 0) begin
          if (cnt_q == TO_LAST) begin
            fetch_err_d = 1'b1;
            cnt_d       = '0;
            state_d     = S_RETRY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_RETRY: state_d = S_FETCH;
      S_VALID: begin
        if (accept) begin
          instr_valid_d = 1'b0;
          pc_d          = next_pc;
          state_d       = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
    imem_req_d = (state_d == S_FETCH);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      pc_out_q      <= RESET_PC;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      fetch_err_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      fetch_err_q   <= fetch_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign instr_valid = instr_valid_q;
  assign pc_out      = pc_out_q;
  assign fetch_err   = fetch_err_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'((state_q == S_FETCH) && imem_ack);
    taken_cnt_d = taken_cnt_q + 32'(accept && (next_pc != pc4));
    stall_cnt_d = stall_cnt_q + 32'((state_q == S_VALID) && instr_valid_q && stall);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      taken_cnt_q <= taken_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign taken_cnt = taken_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
